// File: rtl/spike_logger.sv
// spike_logger: timestamps rising edges of an upstream spike and queues
// {timestamp, membrane state} in a small first-word-fall-through FIFO.
//
// Output handshake: out_valid is high whenever the FIFO holds an entry and
// out_ts/out_state then show the head entry, held stable until accepted.
// The head is consumed in any cycle where out_valid && out_ready.
// out_valid never depends on out_ready.
module spike_logger #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       spike,
  input  logic [7:0]                 state,
  input  logic                       tick,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TS_W-1:0]            out_ts,
  output logic [7:0]                 out_state,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [TS_W-1:0] ts;
  logic            spike_q;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            ovf_q;
  logic [TS_W-1:0] mem_ts [DEPTH];
  logic [7:0]      mem_st [DEPTH];

  logic evt;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Event detection and FIFO accept/drop decisions. A full FIFO still
  // accepts a new event when the head leaves in the same cycle.
  always_comb begin
    evt  = spike & ~spike_q;
    full = (cnt == FULL_CNT);
    pop  = (cnt != '0) & out_ready;
    push = evt & (~full | pop);
    drop = evt & full & ~pop;
  end

  // Timestamp counter: free-running on tick, wraps naturally at 2^TS_W.
  always_ff @(posedge clk) begin
    if (rst) ts <= '0;
    else if (tick) ts <= ts + TS_W'(1);
  end

  // Spike history for rising-edge detection; cleared by reset so a spike
  // already high when reset releases is logged as a fresh event.
  always_ff @(posedge clk) begin
    if (rst) spike_q <= 1'b0;
    else spike_q <= spike;
  end

  // Storage, pointers and occupancy. Entries capture ts before this
  // cycle's increment. Pointers wrap modulo DEPTH (power of two).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_ts[i] <= '0;
        mem_st[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_ts[wr_ptr] <= ts;
        mem_st[wr_ptr] <= state;
        wr_ptr         <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky overflow: a drop beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else if (drop) ovf_q <= 1'b1;
    else if (clr_ovf) ovf_q <= 1'b0;
  end

  assign out_valid = (cnt != '0);
  assign out_ts    = mem_ts[rd_ptr];
  assign out_state = mem_st[rd_ptr];
  assign count     = cnt;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_spike_logger.sv
// Directed bench for spike_logger (DEPTH=4, TS_W=8). Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_spike_logger;

  logic       clk;
  logic       rst;
  logic       spike;
  logic [7:0] state;
  logic       tick;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_ts;
  logic [7:0] out_state;
  logic [2:0] count;
  logic       overflow;
  logic       clr_ovf;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  tb_ts;
  logic [15:0] exp_q[$];

  spike_logger #(.DEPTH(4), .TS_W(8)) dut (
    .clk(clk), .rst(rst), .spike(spike), .state(state), .tick(tick),
    .out_valid(out_valid), .out_ready(out_ready), .out_ts(out_ts),
    .out_state(out_state), .count(count), .overflow(overflow),
    .clr_ovf(clr_ovf)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side time reference used to pick the cycles in which to raise spike.
  always @(posedge clk) begin
    if (rst) tb_ts <= 8'd0;
    else if (tick) tb_ts <= tb_ts + 8'd1;
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; spike = 1'b0; tick = 1'b0; out_ready = 1'b0;
    clr_ovf = 1'b0; state = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0; tick = 1'b1;
  endtask

  task automatic wait_ts(input logic [7:0] t);
    for (int i = 0; i < 600 && tb_ts != t; i++) @(negedge clk);
    if (tb_ts != t) begin
      $display("FAIL wait_ts timeout got=%0d exp=%0d", tb_ts, t); n_err++;
    end
    n_vec++;
  endtask

  // One-cycle spike pulse followed by one low cycle.
  task automatic pulse(input logic [7:0] st);
    spike = 1'b1; state = st;
    @(negedge clk);
    spike = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; spike = 1'b1; tick = 1'b1; out_ready = 1'b1;
    clr_ovf = 1'b0; state = 8'hff;
    repeat (3) @(negedge clk);
    if (out_valid !== 1'b0) begin $display("FAIL rst_valid got=%0b exp=0", out_valid); n_err++; end n_vec++;
    if (count !== 3'd0) begin $display("FAIL rst_count got=%0d exp=0", count); n_err++; end n_vec++;
    if (overflow !== 1'b0) begin $display("FAIL rst_ovf got=%0b exp=0", overflow); n_err++; end n_vec++;
    if (out_ts !== 8'd0) begin $display("FAIL rst_ts got=%0h exp=0", out_ts); n_err++; end n_vec++;
    if (out_state !== 8'd0) begin $display("FAIL rst_state got=%0h exp=0", out_state); n_err++; end n_vec++;
  endtask

  task automatic test_single_event();
    do_reset();
    wait_ts(8'd5);
    if (out_valid !== 1'b0) begin $display("FAIL single_pre_valid got=%0b exp=0", out_valid); n_err++; end n_vec++;
    spike = 1'b1; state = 8'h80;
    @(negedge clk);
    if (out_valid !== 1'b1) begin $display("FAIL single_valid got=%0b exp=1", out_valid); n_err++; end n_vec++;
    if (out_ts !== 8'd5) begin $display("FAIL single_ts got=%0d exp=5", out_ts); n_err++; end n_vec++;
    if (out_state !== 8'h80) begin $display("FAIL single_state got=%0h exp=80", out_state); n_err++; end n_vec++;
    if (count !== 3'd1) begin $display("FAIL single_count got=%0d exp=1", count); n_err++; end n_vec++;
    state = 8'h11;
    repeat (9) @(negedge clk);
    if (count !== 3'd1) begin $display("FAIL single_held_count got=%0d exp=1", count); n_err++; end n_vec++;
    if (out_ts !== 8'd5) begin $display("FAIL single_held_ts got=%0d exp=5", out_ts); n_err++; end n_vec++;
    spike = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if (out_valid !== 1'b0) begin $display("FAIL single_drain_valid got=%0b exp=0", out_valid); n_err++; end n_vec++;
  endtask

  task automatic test_backpressure();
    logic [15:0] e;
    do_reset();
    exp_q.delete();
    wait_ts(8'd1);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back({8'(1 + 2 * i), 8'(8'h10 + i)});
      pulse(8'(8'h10 + i));
    end
    if (count !== 3'd4) begin $display("FAIL bp_count got=%0d exp=4", count); n_err++; end n_vec++;
    if (overflow !== 1'b1) begin $display("FAIL bp_ovf got=%0b exp=1", overflow); n_err++; end n_vec++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (out_valid !== 1'b1) begin $display("FAIL bp_drain_valid got=%0b exp=1", out_valid); n_err++; end n_vec++;
      if ({out_ts, out_state} !== e) begin $display("FAIL bp_drain_entry got=%0h exp=%0h", {out_ts, out_state}, e); n_err++; end n_vec++;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    if (out_valid !== 1'b0) begin $display("FAIL bp_empty_valid got=%0b exp=0", out_valid); n_err++; end n_vec++;
  endtask

  task automatic test_full_with_pop();
    logic [15:0] e;
    do_reset();
    exp_q.delete();
    wait_ts(8'd1);
    for (int i = 0; i < 4; i++) pulse(8'(8'ha0 + i));
    exp_q.push_back({8'd3, 8'ha1});
    exp_q.push_back({8'd5, 8'ha2});
    exp_q.push_back({8'd7, 8'ha3});
    exp_q.push_back({8'd20, 8'h20});
    wait_ts(8'd20);
    if (count !== 3'd4) begin $display("FAIL fp_pre_count got=%0d exp=4", count); n_err++; end n_vec++;
    spike = 1'b1; state = 8'h20; out_ready = 1'b1;
    @(negedge clk);
    if (count !== 3'd4) begin $display("FAIL fp_count got=%0d exp=4", count); n_err++; end n_vec++;
    if (overflow !== 1'b0) begin $display("FAIL fp_ovf got=%0b exp=0", overflow); n_err++; end n_vec++;
    spike = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if ({out_ts, out_state} !== e) begin $display("FAIL fp_drain_entry got=%0h exp=%0h", {out_ts, out_state}, e); n_err++; end n_vec++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    if (out_valid !== 1'b0) begin $display("FAIL fp_empty_valid got=%0b exp=0", out_valid); n_err++; end n_vec++;
  endtask

  task automatic test_ovf_clear();
    do_reset();
    for (int i = 0; i < 4; i++) pulse(8'(8'h50 + i));
    if (overflow !== 1'b0) begin $display("FAIL oc_pre_ovf got=%0b exp=0", overflow); n_err++; end n_vec++;
    spike = 1'b1; clr_ovf = 1'b1;
    @(negedge clk);
    if (overflow !== 1'b1) begin $display("FAIL oc_race_ovf got=%0b exp=1", overflow); n_err++; end n_vec++;
    if (count !== 3'd4) begin $display("FAIL oc_race_count got=%0d exp=4", count); n_err++; end n_vec++;
    if (out_state !== 8'h50) begin $display("FAIL oc_head_state got=%0h exp=50", out_state); n_err++; end n_vec++;
    spike = 1'b0;
    @(negedge clk);
    clr_ovf = 1'b0;
    if (overflow !== 1'b0) begin $display("FAIL oc_clear_ovf got=%0b exp=0", overflow); n_err++; end n_vec++;
  endtask

  task automatic test_wrap_back_to_back();
    do_reset();
    repeat (256) @(negedge clk);
    spike = 1'b1; state = 8'h37;
    @(negedge clk);
    if (out_ts !== 8'd0) begin $display("FAIL wrap_ts got=%0d exp=0", out_ts); n_err++; end n_vec++;
    if (out_state !== 8'h37) begin $display("FAIL wrap_state got=%0h exp=37", out_state); n_err++; end n_vec++;
    @(negedge clk);
    if (count !== 3'd1) begin $display("FAIL wrap_held_count got=%0d exp=1", count); n_err++; end n_vec++;
    spike = 1'b0;
    @(negedge clk);
    spike = 1'b1; state = 8'h44; out_ready = 1'b1;
    @(negedge clk);
    spike = 1'b0;
    if (count !== 3'd1) begin $display("FAIL b2b_count got=%0d exp=1", count); n_err++; end n_vec++;
    if (out_ts !== 8'd3) begin $display("FAIL b2b_ts got=%0d exp=3", out_ts); n_err++; end n_vec++;
    if (out_state !== 8'h44) begin $display("FAIL b2b_state got=%0h exp=44", out_state); n_err++; end n_vec++;
    @(negedge clk);
    out_ready = 1'b0;
    if (count !== 3'd0) begin $display("FAIL b2b_drain_count got=%0d exp=0", count); n_err++; end n_vec++;
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    for (int i = 0; i < 3; i++) pulse(8'(8'h60 + i));
    if (count !== 3'd3) begin $display("FAIL rm_pre_count got=%0d exp=3", count); n_err++; end n_vec++;
    rst = 1'b1; spike = 1'b1; state = 8'h99;
    @(negedge clk);
    if (count !== 3'd0) begin $display("FAIL rm_count got=%0d exp=0", count); n_err++; end n_vec++;
    if (out_valid !== 1'b0) begin $display("FAIL rm_valid got=%0b exp=0", out_valid); n_err++; end n_vec++;
    if (out_ts !== 8'd0) begin $display("FAIL rm_out_ts got=%0d exp=0", out_ts); n_err++; end n_vec++;
    rst = 1'b0;
    @(negedge clk);
    spike = 1'b0;
    if (out_valid !== 1'b1) begin $display("FAIL rm_post_valid got=%0b exp=1", out_valid); n_err++; end n_vec++;
    if (out_ts !== 8'd0) begin $display("FAIL rm_post_ts got=%0d exp=0", out_ts); n_err++; end n_vec++;
    if (out_state !== 8'h99) begin $display("FAIL rm_post_state got=%0h exp=99", out_state); n_err++; end n_vec++;
    if (count !== 3'd1) begin $display("FAIL rm_post_count got=%0d exp=1", count); n_err++; end n_vec++;
  endtask

  // test sequence and final report
  initial begin
    rst = 1'b1; spike = 1'b0; state = 8'h00; tick = 1'b0;
    out_ready = 1'b0; clr_ovf = 1'b0;
    test_reset();
    test_single_event();
    test_backpressure();
    test_full_with_pop();
    test_ovf_clear();
    test_wrap_back_to_back();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
